swap_register_bank: RTL

- Clocked, parametrised successor of the two-register swap block.
- Holds DEPTH registers of width N and executes commands over a valid/ready handshake: LOAD, SWAP of any two entries, ROTATE of the whole bank.
- SWAP is sequenced through a single write path and a temp register, so it is multi-cycle.
- Sits between a control sequencer and datapath consumers; provides a registered read port and a swap counter.

---
 rtl/swap_register_bank_pkg.sv | 21 ++
 rtl/swap_register_bank.sv | 116 +++++++++++
 2 files changed

// File: rtl/swap_register_bank_pkg.sv
// Shared definitions for the swap register bank: command opcodes, FSM states
// and the index-width helper.
package swap_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_SWAP   = 2'b10;
  localparam logic [1:0] OP_ROTATE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWAP1 = 2'b01,
    SWAP2 = 2'b10
  } state_t;

  // A bank of two entries still needs one index bit.
  function automatic int idx_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/swap_register_bank.sv
// Bank of DEPTH registers driven by a command port (LOAD / SWAP / ROTATE / NOP),
// with a registered read port and a completed-swap counter.
module swap_register_bank
  import swap_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 16,
  localparam int IDX_W = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
  // the command fields are sampled only on that edge.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx_a,
  input  logic [IDX_W-1:0] cmd_idx_b,
  input  logic [N-1:0]     cmd_data,
  output logic             done,
  output logic             err,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [N-1:0]     rd_data,
  output logic [CNT_W-1:0] swap_count,
  output logic [1:0]       dbg_state
);

  logic [N-1:0]     r_bank [DEPTH];
  logic [N-1:0]     r_tmp;
  logic [N-1:0]     r_rd_data;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_a;
  logic [IDX_W-1:0] r_b;
  logic             r_done;
  logic             r_err;
  state_t           r_state;

  logic w_a_ok;
  logic w_b_ok;
  logic w_rd_ok;

  // DEPTH need not be a power of two, so every index is range-checked.
  assign w_a_ok  = ({1'b0, cmd_idx_a} < (IDX_W+1)'(DEPTH));
  assign w_b_ok  = ({1'b0, cmd_idx_b} < (IDX_W+1)'(DEPTH));
  assign w_rd_ok = ({1'b0, rd_idx}    < (IDX_W+1)'(DEPTH));

  assign cmd_ready  = (r_state == IDLE) && !reset;
  assign done       = r_done;
  assign err        = r_err;
  assign rd_data    = r_rd_data;
  assign swap_count = r_count;
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
      r_tmp     <= '0;
      r_rd_data <= '0;
      r_count   <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_state   <= IDLE;
    end else begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= w_rd_ok ? r_bank[rd_idx] : '0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                if (w_a_ok) begin
                  r_bank[cmd_idx_a] <= cmd_data;
                  r_done            <= 1'b1;
                end else begin
                  r_err <= 1'b1;
                end
              end
              OP_SWAP: begin
                if (w_a_ok && w_b_ok) begin
                  r_a     <= cmd_idx_a;
                  r_b     <= cmd_idx_b;
                  r_state <= SWAP1;
                end else begin
                  r_err <= 1'b1;
                end
              end
              OP_ROTATE: begin
                // Rotate toward index 0; entry 0 wraps to the top.
                for (int i = 0; i < DEPTH; i++) r_bank[i] <= r_bank[(i + 1) % DEPTH];
                r_done <= 1'b1;
              end
              default: r_done <= 1'b1;
            endcase
          end
        end
        SWAP1: begin
          r_tmp       <= r_bank[r_a];
          r_bank[r_a] <= r_bank[r_b];
          r_state     <= SWAP2;
        end
        SWAP2: begin
          r_bank[r_b] <= r_tmp;
          r_count     <= r_count + CNT_W'(1);
          r_done      <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
